// File: rtl/debounce_sync.sv
// Switch/pin debouncer: multi-flop synchronizer, four-state qualification FSM,
// registered edge pulses and a saturating count of rejected transitions.
module debounce_sync #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 16,
    parameter int GLITCH_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                raw_i,
    input  logic                en_i,
    input  logic                clr_i,
    output logic                level_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic [GLITCH_W-1:0] glitch_cnt_o,
    output logic [1:0]          state_o
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [1:0] STABLE_LO = 2'd0;
    localparam logic [1:0] CHK_HI    = 2'd1;
    localparam logic [1:0] STABLE_HI = 2'd2;
    localparam logic [1:0] CHK_LO    = 2'd3;

    localparam logic [CW-1:0]       CNT_LAST   = CW'(DEBOUNCE_CYC - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_d, rise_d, fall_d;
    logic                   glitch_inc;

    // Only the last synchronizer stage may be observed by the rest of the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        level_d    = level_o;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        glitch_inc = 1'b0;
        case (state_q)
            STABLE_LO: begin
                cnt_d = '0;
                if (en_i && sync) begin
                    state_d = CHK_HI;
                    cnt_d   = CW'(1);
                end
            end
            CHK_HI: begin
                // Disabling abandons qualification without counting it as a glitch.
                if (!en_i) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (!sync) begin
                    state_d    = STABLE_LO;
                    cnt_d      = '0;
                    glitch_inc = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STABLE_HI: begin
                cnt_d = '0;
                if (en_i && !sync) begin
                    state_d = CHK_LO;
                    cnt_d   = CW'(1);
                end
            end
            CHK_LO: begin
                if (!en_i) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (sync) begin
                    state_d    = STABLE_HI;
                    cnt_d      = '0;
                    glitch_inc = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_o <= 1'b0;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_o <= level_d;
            rise_o  <= rise_d;
            fall_o  <= fall_d;
        end
    end

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt_o <= '0;
        end else if (clr_i) begin
            glitch_cnt_o <= '0;
        end else if (glitch_inc && (glitch_cnt_o != GLITCH_MAX)) begin
            glitch_cnt_o <= glitch_cnt_o + GLITCH_W'(1);
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync at default parameters: vector table of timed segments
// plus hand sequences for saturation, clear priority and asynchronous reset.
module tb_debounce_sync;

    localparam int W = 25;

    logic       clk;
    logic       rst_n;
    logic       raw_i;
    logic       en_i;
    logic       clr_i;
    logic       level_o;
    logic       rise_o;
    logic       fall_o;
    logic [7:0] glitch_cnt_o;
    logic [1:0] state_o;

    debounce_sync #(
        .SYNC_STAGES (2),
        .DEBOUNCE_CYC(16),
        .GLITCH_W    (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw_i       (raw_i),
        .en_i        (en_i),
        .clr_i       (clr_i),
        .level_o     (level_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .glitch_cnt_o(glitch_cnt_o),
        .state_o     (state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic  raw;
        logic  en;
        logic  clr;
        int    cycles;
        logic  exp_level;
        int    exp_glitch;
        int    exp_rise;
        int    exp_fall;
        string name;
    } vec_t;

    vec_t           vecs[19];
    logic [W-1:0]   exp_q[$];
    int             tests_run;
    int             tests_failed;
    int             acc_rise;
    int             acc_fall;
    int             pulse_viol;
    logic           prev_pulse;

    // pulse rules: never both, never on consecutive cycles
    initial begin
        pulse_viol = 0;
        prev_pulse = 1'b0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rise_o && fall_o) pulse_viol = pulse_viol + 1;
            if ((rise_o || fall_o) && prev_pulse) pulse_viol = pulse_viol + 1;
            prev_pulse = rise_o || fall_o;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    // driver tasks: called just after a falling edge, return just after one
    task automatic drive(input logic raw, input logic en, input logic clr, input int n);
        raw_i = raw;
        en_i  = en;
        clr_i = clr;
        repeat (n) begin
            @(negedge clk);
            acc_rise = acc_rise + int'(rise_o);
            acc_fall = acc_fall + int'(fall_o);
        end
    endtask

    task automatic expect_out(input logic lvl, input int g, input int r, input int f);
        exp_q.push_back({lvl, 8'(g), 8'(r), 8'(f)});
        acc_rise = 0;
        acc_fall = 0;
    endtask

    // scoreboard: pop the oldest expectation and compare to observed outputs
    task automatic check(input string name);
        logic [W-1:0] got;
        logic [W-1:0] exp;
        got = {level_o, glitch_cnt_o, 8'(acc_rise), 8'(acc_fall)};
        tests_run = tests_run + 1;
        if (exp_q.size() == 0) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: no expectation queued", name);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                tests_failed = tests_failed + 1;
                $display("FAIL %s: got level=%0d glitch=%0d rise=%0d fall=%0d, required level=%0d glitch=%0d rise=%0d fall=%0d",
                         name, got[24], got[23:16], got[15:8], got[7:0],
                         exp[24], exp[23:16], exp[15:8], exp[7:0]);
            end
        end
    endtask

    task automatic run_seg(input vec_t v);
        expect_out(v.exp_level, v.exp_glitch, v.exp_rise, v.exp_fall);
        drive(v.raw, v.en, v.clr, v.cycles);
        check(v.name);
    endtask

    task automatic check_now(input string name, input logic lvl, input int g);
        expect_out(lvl, g, 0, 0);
        acc_rise = int'(rise_o);
        acc_fall = int'(fall_o);
        check(name);
    endtask

    initial begin
        int n_glitch;
        int exp_sat;

        tests_run    = 0;
        tests_failed = 0;
        acc_rise     = 0;
        acc_fall     = 0;

        // raw, en, clr, cycles, level, glitch, rise, fall, name
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 17, 1'b0, 0, 0, 0, "rise_wait17"};
        vecs[1]  = '{1'b1, 1'b1, 1'b0,  1, 1'b1, 0, 1, 0, "rise_edge18"};
        vecs[2]  = '{1'b1, 1'b1, 1'b0,  1, 1'b1, 0, 0, 0, "rise_one_cycle"};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 20, 1'b1, 0, 0, 0, "hold_hi"};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 17, 1'b1, 0, 0, 0, "fall_wait17"};
        vecs[5]  = '{1'b0, 1'b1, 1'b0,  1, 1'b0, 0, 0, 1, "fall_edge18"};
        vecs[6]  = '{1'b0, 1'b1, 1'b0,  5, 1'b0, 0, 0, 0, "hold_lo"};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 10, 1'b0, 0, 0, 0, "glitch_hi10"};
        vecs[8]  = '{1'b0, 1'b1, 1'b0,  5, 1'b0, 1, 0, 0, "glitch_rejected"};
        vecs[9]  = '{1'b1, 1'b1, 1'b0,  8, 1'b0, 1, 0, 0, "en_qual_partial"};
        vecs[10] = '{1'b1, 1'b0, 1'b0,  5, 1'b0, 1, 0, 0, "en_off_abort"};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 15, 1'b0, 1, 0, 0, "en_restart_wait"};
        vecs[12] = '{1'b1, 1'b1, 1'b0,  1, 1'b1, 1, 1, 0, "en_restart_rise"};
        vecs[13] = '{1'b0, 1'b1, 1'b0,  6, 1'b1, 1, 0, 0, "lo_qual_partial"};
        vecs[14] = '{1'b0, 1'b0, 1'b0,  4, 1'b1, 1, 0, 0, "lo_en_off_abort"};
        vecs[15] = '{1'b1, 1'b1, 1'b0,  5, 1'b1, 2, 0, 0, "lo_resume_glitch"};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 18, 1'b0, 2, 0, 1, "fall_full18"};
        vecs[17] = '{1'b0, 1'b1, 1'b1,  1, 1'b0, 0, 0, 0, "clr_glitch"};
        vecs[18] = '{1'b0, 1'b1, 1'b0,  3, 1'b0, 0, 0, 0, "post_clr"};

        rst_n = 1'b0;
        raw_i = 1'b0;
        en_i  = 1'b0;
        clr_i = 1'b0;
        repeat (3) @(negedge clk);
        check_now("reset_state", 1'b0, 0);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 3);

        for (int i = 0; i < 19; i++) run_seg(vecs[i]);

        // saturation: each 8-cycle period yields exactly one rejected transition
        n_glitch = 300;
        exp_sat  = (n_glitch > 255) ? 255 : n_glitch;
        expect_out(1'b0, exp_sat, 0, 0);
        for (int k = 0; k < n_glitch; k++) begin
            drive(1'b1, 1'b1, 1'b0, 4);
            drive(1'b0, 1'b1, 1'b0, 4);
        end
        check("glitch_saturate");

        // clear lands on the same edge as a rejected transition
        expect_out(1'b0, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 4);
        drive(1'b0, 1'b1, 1'b0, 2);
        drive(1'b0, 1'b1, 1'b1, 1);
        drive(1'b0, 1'b1, 1'b0, 1);
        check("clr_beats_inc");

        expect_out(1'b0, 1, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 4);
        drive(1'b0, 1'b1, 1'b0, 4);
        check("pre_reset_glitch");

        // reset asserted mid-qualification, sampled before any rising edge
        drive(1'b1, 1'b1, 1'b0, 6);
        rst_n = 1'b0;
        #2;
        check_now("async_rst_chk_hi", 1'b0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_seg('{1'b1, 1'b1, 1'b0, 17, 1'b0, 0, 0, 0, "rel_hi_wait17"});
        run_seg('{1'b1, 1'b1, 1'b0,  1, 1'b1, 0, 1, 0, "rel_hi_rise18"});

        rst_n = 1'b0;
        #2;
        check_now("async_rst_level_hi", 1'b0, 0);
        raw_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_seg('{1'b0, 1'b1, 1'b0, 25, 1'b0, 0, 0, 0, "rel_lo_no_pulse"});

        tests_run = tests_run + 1;
        if (pulse_viol != 0) begin
            tests_failed = tests_failed + 1;
            $display("FAIL pulse_rules: got %0d violations, required 0", pulse_viol);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
